// File: rtl/alu_multicycle.sv
// alu_multicycle
//   Multi-cycle ALU with registered result/flags and a start/busy/done
//   handshake. ADD/SUB/NAND complete in one cycle. Shifts move one bit per
//   cycle for k = b[SW-1:0] cycles. MUL is a WIDTH-iteration shift-add.
//
// Ports
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   start    request, accepted only while busy=0
//   op       001 ADD, 010 SUB, 011 NAND, 100 SHL, 101 SHR, 110 MUL, others reserved
//   a, b     operands (b[SW-1:0] is the shift amount for shifts)
//   busy     high while an op is in flight, including the done cycle
//   done     one-cycle pulse, result/flags valid from this cycle on
//   result   registered result
//   z,n,c,v  zero/shifted-out, negative, carry/borrow/upper-product, overflow
//
// state  | meaning
// IDLE   | waiting for start; result/flags hold
// RUN    | shift or multiply iterating, cnt counts remaining steps down
// DONE   | result/flags just written; done pulses, start ignored

module alu_multicycle #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             n,
  output logic             c,
  output logic             v
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;   // must hold WIDTH for the multiply count

  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q;       // shift register for shifts, multiplicand for MUL
  logic [2*WIDTH-1:0] prod_q;    // {partial high, remaining multiplier}
  logic [CW-1:0]      cnt;

  logic [SW-1:0]      k;
  logic [WIDTH:0]     add_full;
  logic [WIDTH:0]     sub_full;
  logic [WIDTH-1:0]   nand_res;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH-1:0]   shl_next;
  logic [WIDTH-1:0]   shr_next;
  logic               last_step;

  assign k = b[SW-1:0];

  always_comb begin
    add_full  = {1'b0, a} + {1'b0, b};
    sub_full  = {1'b0, a} - {1'b0, b};
    nand_res  = ~(a & b);
    // Add the multiplicand into the high half when the current multiplier
    // bit is set, then shift the whole product right, keeping the carry.
    mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
              + (prod_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    prod_next = {mul_sum, prod_q[WIDTH-1:1]};
    shl_next  = {a_q[WIDTH-2:0], 1'b0};
    shr_next  = {1'b0, a_q[WIDTH-1:1]};
    last_step = (cnt == CW'(1));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      op_q   <= 3'b000;
      a_q    <= '0;
      prod_q <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      z      <= 1'b0;
      n      <= 1'b0;
      c      <= 1'b0;
      v      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q   <= op;
            a_q    <= a;
            prod_q <= {{WIDTH{1'b0}}, b};
            cnt    <= {1'b0, k};
            busy   <= 1'b1;
            state  <= S_DONE;
            done   <= 1'b1;
            case (op)
              OP_ADD: begin
                result <= add_full[WIDTH-1:0];
                z      <= (add_full[WIDTH-1:0] == '0);
                n      <= add_full[WIDTH-1];
                c      <= add_full[WIDTH];
                v      <= (a[WIDTH-1] == b[WIDTH-1]) &&
                          (add_full[WIDTH-1] != a[WIDTH-1]);
              end
              OP_SUB: begin
                result <= sub_full[WIDTH-1:0];
                z      <= (sub_full[WIDTH-1:0] == '0);
                n      <= sub_full[WIDTH-1];
                c      <= sub_full[WIDTH];
                v      <= (a[WIDTH-1] != b[WIDTH-1]) &&
                          (sub_full[WIDTH-1] != a[WIDTH-1]);
              end
              OP_NAND: begin
                result <= nand_res;
                z      <= (nand_res == '0);
                n      <= nand_res[WIDTH-1];
                c      <= 1'b0;
                v      <= 1'b0;
              end
              OP_SHL, OP_SHR: begin
                if (k == '0) begin
                  result <= a;
                  z      <= 1'b0;
                  n      <= 1'b0;
                  c      <= 1'b0;
                  v      <= 1'b0;
                end else begin
                  state <= S_RUN;
                  done  <= 1'b0;
                end
              end
              OP_MUL: begin
                cnt   <= CW'(WIDTH);
                state <= S_RUN;
                done  <= 1'b0;
              end
              default: ;  // reserved: outputs hold, done still pulses
            endcase
          end
        end

        S_RUN: begin
          cnt <= cnt - CW'(1);
          case (op_q)
            OP_SHL:  a_q    <= shl_next;
            OP_SHR:  a_q    <= shr_next;
            default: prod_q <= prod_next;
          endcase
          if (last_step) begin
            state <= S_DONE;
            done  <= 1'b1;
            case (op_q)
              OP_SHL: begin
                result <= shl_next;
                z      <= a_q[WIDTH-1];
                n      <= 1'b0;
                c      <= 1'b0;
                v      <= 1'b0;
              end
              OP_SHR: begin
                result <= shr_next;
                z      <= a_q[0];
                n      <= 1'b0;
                c      <= 1'b0;
                v      <= 1'b0;
              end
              default: begin
                result <= prod_next[WIDTH-1:0];
                z      <= (prod_next[WIDTH-1:0] == '0);
                n      <= prod_next[WIDTH-1];
                c      <= |prod_next[2*WIDTH-1:WIDTH];
                v      <= 1'b0;
              end
            endcase
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
module tb_alu_multicycle;

  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] op = 3'b000;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       busy, done, z, n, c, v;
  logic [7:0] result;

  int tests = 0;
  int fails = 0;

  // reference model state: last committed result/flags
  int m_res = 0, m_z = 0, m_n = 0, m_c = 0, m_v = 0;

  alu_multicycle #(.WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .z(z), .n(n), .c(c), .v(v)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".result"}, int'(result), m_res);
    chk({tag, ".z"}, int'(z), m_z);
    chk({tag, ".n"}, int'(n), m_n);
    chk({tag, ".c"}, int'(c), m_c);
    chk({tag, ".v"}, int'(v), m_v);
  endtask

  // Applies one op to the model with plain integer arithmetic; returns latency.
  function automatic int model_apply(input logic [2:0] o, input logic [7:0] aa, input logic [7:0] bb);
    int ua = int'(aa);
    int ub = int'(bb);
    int sa = (ua >= 128) ? ua - 256 : ua;
    int sb = (ub >= 128) ? ub - 256 : ub;
    int kk = ub % 8;
    int s, sr, p;
    case (o)
      OP_ADD: begin
        s = ua + ub; sr = sa + sb;
        m_res = s % 256; m_c = (s > 255) ? 1 : 0;
        m_v = (sr > 127 || sr < -128) ? 1 : 0;
      end
      OP_SUB: begin
        s = ua - ub + 256; sr = sa - sb;
        m_res = s % 256; m_c = (ua < ub) ? 1 : 0;
        m_v = (sr > 127 || sr < -128) ? 1 : 0;
      end
      OP_NAND: begin
        m_res = 255 - (ua & ub); m_c = 0; m_v = 0;
      end
      OP_MUL: begin
        p = ua * ub;
        m_res = p % 256; m_c = (p / 256 != 0) ? 1 : 0; m_v = 0;
      end
      OP_SHL: begin
        m_res = (ua * (1 << kk)) % 256;
        m_z = (kk == 0) ? 0 : (ua >> (8 - kk)) % 2;
        m_n = 0; m_c = 0; m_v = 0;
        return kk + 1;
      end
      OP_SHR: begin
        m_res = ua >> kk;
        m_z = (kk == 0) ? 0 : (ua >> (kk - 1)) % 2;
        m_n = 0; m_c = 0; m_v = 0;
        return kk + 1;
      end
      default: return 1;
    endcase
    m_z = (m_res == 0) ? 1 : 0;
    m_n = (m_res >= 128) ? 1 : 0;
    return (o == OP_MUL) ? 9 : 1;
  endfunction

  // Caller is just past a negedge with the DUT idle.
  task automatic run_op(input logic [2:0] o, input logic [7:0] aa, input logic [7:0] bb, input string tag);
    int lat, cyc;
    bit busy_ok;
    chk({tag, ".idle_busy"}, int'(busy), 0);
    lat = model_apply(o, aa, bb);
    op = o; a = aa; b = bb; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
    cyc = 0; busy_ok = 1'b1;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) break;
    end
    chk({tag, ".latency"}, cyc, lat);
    chk({tag, ".busy_held"}, int'(busy_ok), 1);
    chk_outputs(tag);
    @(negedge clk);
    chk({tag, ".busy_after"}, int'(busy), 0);
    chk({tag, ".done_after"}, int'(done), 0);
  endtask

  initial begin
    int cyc, lat;
    bit got, done_seen;

    // reset state
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.busy", int'(busy), 0);
    chk("reset.done", int'(done), 0);
    chk_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // 1. ADD with signed overflow
    run_op(OP_ADD, 8'h7F, 8'h01, "add_ovf");
    // 2. SUB equal, then SUB with borrow
    run_op(OP_SUB, 8'h05, 8'h05, "sub_zero");
    run_op(OP_SUB, 8'h03, 8'h05, "sub_borrow");
    // 3. shifts
    run_op(OP_SHR, 8'h05, 8'h01, "shr1");
    run_op(OP_SHL, 8'h81, 8'h03, "shl3");
    run_op(OP_SHL, 8'hA5, 8'h00, "shl0");
    run_op(OP_SHR, 8'h80, 8'h07, "shr7");
    run_op(OP_NAND, 8'hF0, 8'hFF, "nand");
    // reserved op holds previous result and flags
    run_op(3'b000, 8'h12, 8'h34, "rsv0");
    run_op(3'b111, 8'h00, 8'h00, "rsv7");
    // 4. MUL
    run_op(OP_MUL, 8'h0C, 8'h0D, "mul_small");
    run_op(OP_MUL, 8'h10, 8'h10, "mul_carry");
    run_op(OP_MUL, 8'hFF, 8'hFF, "mul_max");

    // 5. starts during busy (cycle 3 and the done cycle 9) are ignored
    lat = model_apply(OP_MUL, 8'h03, 8'h07);
    op = OP_MUL; a = 8'h03; b = 8'h07; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0; got = 1'b0;
    while (cyc < 20 && !got) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) got = 1'b1;
      if (cyc == 3 || cyc == 9) begin
        start = 1'b1; op = OP_ADD; a = 8'h01; b = 8'h01;
      end else begin
        start = 1'b0;
      end
    end
    chk("busy_start.latency", cyc, lat);
    chk_outputs("busy_start.mul");
    @(negedge clk);
    start = 1'b0;
    chk("busy_start.c10_busy", int'(busy), 0);
    chk("busy_start.c10_done", int'(done), 0);
    chk_outputs("busy_start.c10_hold");
    // accepted at the edge ending cycle 10
    run_op(OP_ADD, 8'h01, 8'h01, "busy_start.next");

    // 6. reset in the middle of a MUL
    op = OP_MUL; a = 8'h0C; b = 8'h0D; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    m_res = 0; m_z = 0; m_n = 0; m_c = 0; m_v = 0;
    chk("midreset.busy", int'(busy), 0);
    chk("midreset.done", int'(done), 0);
    chk_outputs("midreset");
    done_seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) done_seen = 1'b1;
    end
    chk("midreset.no_done", int'(done_seen), 0);
    run_op(OP_ADD, 8'h7F, 8'h01, "midreset.add");

    // random ops against the model
    for (int i = 0; i < 60; i++) begin
      run_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
